// File: rtl/wb_regfile_if.sv
// Operand bus between EX, ID and the combined post-EX pipeline / register file.
// The master side is the core driving results and read requests; the slave side is wb_regfile.
interface wb_regfile_if #(
  parameter int DATA_W = 32
);
  logic              stall_i;
  logic              flush_i;
  logic [4:0]        ex_wd_i;
  logic              ex_wreg_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              re1_i;
  logic [4:0]        raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [4:0]        raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic [4:0]        wb_wd_o;
  logic              wb_wreg_o;
  logic [DATA_W-1:0] wb_wdata_o;

  modport master (
    output stall_i, flush_i, ex_wd_i, ex_wreg_i, ex_wdata_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, wb_wd_o, wb_wreg_o, wb_wdata_o
  );

  modport slave (
    input  stall_i, flush_i, ex_wd_i, ex_wreg_i, ex_wdata_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, wb_wd_o, wb_wreg_o, wb_wdata_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Post-EX result pipeline (PIPE_DEPTH stages) feeding a 32 x DATA_W register file,
// with two combinational read ports that forward from EX and every in-flight stage.
module wb_regfile #(
  parameter int PIPE_DEPTH = 2,
  parameter int DATA_W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [4:0]        w_stg_wd    [PIPE_DEPTH];
  logic              w_stg_wreg  [PIPE_DEPTH];
  logic [DATA_W-1:0] w_stg_wdata [PIPE_DEPTH];
  logic [DATA_W-1:0] w_regs      [32];
  logic              w_commit;
  logic              w_re        [2];
  logic [4:0]        w_raddr     [2];

  // Commit is gated by stall only; a flush still lets the oldest entry retire.
  assign w_commit = ~bus.stall_i & w_stg_wreg[PIPE_DEPTH-1] &
                    (w_stg_wd[PIPE_DEPTH-1] != 5'd0);

  assign bus.wb_wd_o    = w_stg_wd[PIPE_DEPTH-1];
  assign bus.wb_wreg_o  = w_stg_wreg[PIPE_DEPTH-1];
  assign bus.wb_wdata_o = w_stg_wdata[PIPE_DEPTH-1];

  genvar gk;
  generate
    for (gk = 0; gk < PIPE_DEPTH; gk++) begin : g_stage
      logic [4:0]        r_wd;
      logic              r_wreg;
      logic [DATA_W-1:0] r_wdata;
      logic [4:0]        w_nxt_wd;
      logic              w_nxt_wreg;
      logic [DATA_W-1:0] w_nxt_wdata;

      if (gk == 0) begin : g_head
        assign w_nxt_wd    = bus.ex_wd_i;
        assign w_nxt_wreg  = bus.ex_wreg_i;
        assign w_nxt_wdata = bus.ex_wdata_i;
      end else begin : g_tail
        assign w_nxt_wd    = g_stage[gk-1].r_wd;
        assign w_nxt_wreg  = g_stage[gk-1].r_wreg;
        assign w_nxt_wdata = g_stage[gk-1].r_wdata;
      end

      // Stage register: reset and flush clear it, stall holds it, otherwise it advances.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wd    <= 5'd0;
          r_wreg  <= 1'b0;
          r_wdata <= {DATA_W{1'b0}};
        end else if (bus.flush_i) begin
          r_wd    <= 5'd0;
          r_wreg  <= 1'b0;
          r_wdata <= {DATA_W{1'b0}};
        end else if (!bus.stall_i) begin
          r_wd    <= w_nxt_wd;
          r_wreg  <= w_nxt_wreg;
          r_wdata <= w_nxt_wdata;
        end
      end

      assign w_stg_wd[gk]    = r_wd;
      assign w_stg_wreg[gk]  = r_wreg;
      assign w_stg_wdata[gk] = r_wdata;
    end
  endgenerate

  genvar gr;
  generate
    for (gr = 0; gr < 32; gr++) begin : g_reg
      if (gr == 0) begin : g_zero
        assign w_regs[gr] = {DATA_W{1'b0}};
      end else begin : g_live
        logic [DATA_W-1:0] r_reg;

        // Architectural register, written only by the commit stage.
        always_ff @(posedge clk) begin
          if (rst) begin
            r_reg <= {DATA_W{1'b0}};
          end else if (w_commit && (w_stg_wd[PIPE_DEPTH-1] == 5'(gr))) begin
            r_reg <= w_stg_wdata[PIPE_DEPTH-1];
          end
        end

        assign w_regs[gr] = r_reg;
      end
    end
  endgenerate

  assign w_re[0]    = bus.re1_i;
  assign w_raddr[0] = bus.raddr1_i;
  assign w_re[1]    = bus.re2_i;
  assign w_raddr[1] = bus.raddr2_i;

  genvar gp;
  generate
    for (gp = 0; gp < 2; gp++) begin : g_port
      logic [DATA_W-1:0] w_out;

      // Priority chain built from the oldest stage towards S0 so the newest match wins.
      for (gk = 0; gk < PIPE_DEPTH; gk++) begin : g_fwd
        logic [DATA_W-1:0] w_older;
        logic [DATA_W-1:0] w_val;

        if (gk == PIPE_DEPTH - 1) begin : g_last
          assign w_older = w_regs[w_raddr[gp]];
        end else begin : g_mid
          assign w_older = g_fwd[gk+1].w_val;
        end

        assign w_val = (w_stg_wreg[gk] && (w_stg_wd[gk] == w_raddr[gp])) ?
                       w_stg_wdata[gk] : w_older;
      end

      // Final read mux: disabled port and r0 read zero, then EX bypass, then stages/file.
      always_comb begin
        w_out = {DATA_W{1'b0}};
        if (!w_re[gp] || (w_raddr[gp] == 5'd0)) begin
          w_out = {DATA_W{1'b0}};
        end else if (bus.ex_wreg_i && (bus.ex_wd_i == w_raddr[gp])) begin
          w_out = bus.ex_wdata_i;
        end else begin
          w_out = g_fwd[0].w_val;
        end
      end
    end
  endgenerate

  assign bus.rdata1_o = g_port[0].w_out;
  assign bus.rdata2_o = g_port[1].w_out;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scenarios followed by random traffic, all checked against a queue-based
// model of the in-flight results and a plain array for the register file.
module tb_wb_regfile;
  localparam int D = 2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if #(.DATA_W(W)) bus ();

  wb_regfile #(.PIPE_DEPTH(D), .DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]   wd;
    logic         wreg;
    logic [W-1:0] wdata;
  } ent_t;

  ent_t         m_pipe [$];   // index 0 = newest in-flight result
  logic [W-1:0] m_regs [32];
  int           n_vec   = 0;
  int           n_err   = 0;
  bit           m_check = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic re, input logic [4:0] a);
    if (!re || a == 5'd0) return 32'd0;
    if (bus.ex_wreg_i && bus.ex_wd_i == a) return bus.ex_wdata_i;
    foreach (m_pipe[i]) begin
      if (m_pipe[i].wreg && m_pipe[i].wd == a) return m_pipe[i].wdata;
    end
    return m_regs[a];
  endfunction

  task automatic m_clear();
    m_pipe.delete();
    repeat (D) m_pipe.push_back('0);
  endtask

  task automatic m_edge();
    ent_t ex;
    ent_t old;
    ex.wd    = bus.ex_wd_i;
    ex.wreg  = bus.ex_wreg_i;
    ex.wdata = bus.ex_wdata_i;
    old      = m_pipe[D-1];
    if (rst) begin
      m_clear();
      foreach (m_regs[i]) m_regs[i] = 32'd0;
    end else begin
      if (!bus.stall_i && old.wreg && old.wd != 5'd0) m_regs[old.wd] = old.wdata;
      if (bus.flush_i) m_clear();
      else if (!bus.stall_i) begin
        m_pipe.push_front(ex);
        void'(m_pipe.pop_back());
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (m_check) begin
      chk("rdata1", bus.rdata1_o, m_read(bus.re1_i, bus.raddr1_i));
      chk("rdata2", bus.rdata2_o, m_read(bus.re2_i, bus.raddr2_i));
      chk("wb_wd", 32'(bus.wb_wd_o), 32'(m_pipe[D-1].wd));
      chk("wb_wreg", 32'(bus.wb_wreg_o), 32'(m_pipe[D-1].wreg));
      chk("wb_wdata", bus.wb_wdata_o, m_pipe[D-1].wdata);
    end
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic set_ex(input logic wreg, input logic [4:0] wd, input logic [W-1:0] wdata);
    bus.ex_wreg_i  = wreg;
    bus.ex_wd_i    = wd;
    bus.ex_wdata_i = wdata;
  endtask

  task automatic set_rd(input logic re1, input logic [4:0] a1, input logic re2, input logic [4:0] a2);
    bus.re1_i    = re1;
    bus.raddr1_i = a1;
    bus.re2_i    = re2;
    bus.raddr2_i = a2;
  endtask

  initial begin
    m_clear();
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    rst         = 1'b1;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    set_ex(1'b0, 5'd0, 32'd0);
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    step();
    step();
    rst     = 1'b0;
    m_check = 1'b1;

    // reset clears committed registers
    set_ex(1'b1, 5'd5, 32'h0000_1234);
    step();
    set_ex(1'b0, 5'd0, 32'd0);
    step();
    step();
    set_rd(1'b1, 5'd5, 1'b0, 5'd0);
    #1 chk("r5_before_rst", bus.rdata1_o, 32'h0000_1234);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1 chk("r5_after_rst", bus.rdata1_o, 32'd0);
    chk("wb_wreg_after_rst", 32'(bus.wb_wreg_o), 32'd0);

    // basic commit path
    set_ex(1'b1, 5'd3, 32'hA5A5_A5A5);
    set_rd(1'b1, 5'd3, 1'b0, 5'd0);
    #1 chk("r3_fwd_ex", bus.rdata1_o, 32'hA5A5_A5A5);
    step();
    set_ex(1'b0, 5'd0, 32'd0);
    #1 chk("r3_fwd_s0", bus.rdata1_o, 32'hA5A5_A5A5);
    step();
    #1 chk("wb_wd_r3", 32'(bus.wb_wd_o), 32'd3);
    chk("wb_wdata_r3", bus.wb_wdata_o, 32'hA5A5_A5A5);
    step();
    #1 chk("r3_from_file", bus.rdata1_o, 32'hA5A5_A5A5);

    // forwarding priority EX > S0 > S1
    set_ex(1'b1, 5'd7, 32'h11);
    step();
    set_ex(1'b1, 5'd7, 32'h22);
    step();
    set_ex(1'b1, 5'd7, 32'h33);
    set_rd(1'b0, 5'd0, 1'b1, 5'd7);
    #1 chk("r7_ex_wins", bus.rdata2_o, 32'h33);
    bus.ex_wreg_i = 1'b0;
    #1 chk("r7_s0_wins", bus.rdata2_o, 32'h22);
    step();
    step();
    step();
    #1 chk("r7_committed", bus.rdata2_o, 32'h22);

    // r0 is never written, disabled ports read zero
    set_ex(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(1'b1, 5'd0, 1'b1, 5'd0);
    #1 chk("r0_ex_rd1", bus.rdata1_o, 32'd0);
    chk("r0_ex_rd2", bus.rdata2_o, 32'd0);
    step();
    set_ex(1'b0, 5'd0, 32'd0);
    step();
    step();
    #1 chk("r0_after", bus.rdata1_o, 32'd0);
    set_rd(1'b0, 5'd3, 1'b1, 5'd3);
    #1 chk("rd1_disabled", bus.rdata1_o, 32'd0);
    chk("rd2_r3", bus.rdata2_o, 32'hA5A5_A5A5);
    bus.re1_i = 1'b1;
    #1 chk("rd1_r3_same", bus.rdata1_o, 32'hA5A5_A5A5);

    // stall holds S1 and blocks commit; EX ignored meanwhile
    set_ex(1'b1, 5'd9, 32'h55);
    step();
    set_ex(1'b0, 5'd0, 32'd0);
    step();
    bus.stall_i = 1'b1;
    set_ex(1'b1, 5'd10, 32'h0000_0BAD);
    set_rd(1'b1, 5'd9, 1'b1, 5'd10);
    for (int i = 0; i < 3; i++) begin
      #1 chk("r9_stalled_fwd", bus.rdata1_o, 32'h55);
      chk("wb_wd_stalled", 32'(bus.wb_wd_o), 32'd9);
      step();
    end
    bus.stall_i = 1'b0;
    set_ex(1'b0, 5'd0, 32'd0);
    #1 chk("r9_unstall_fwd", bus.rdata1_o, 32'h55);
    chk("wb_wreg_unstall", 32'(bus.wb_wreg_o), 32'd1);
    step();
    #1 chk("r9_committed", bus.rdata1_o, 32'h55);
    chk("r10_ignored", bus.rdata2_o, 32'd0);

    // flush together with stall drops the commit-stage entry
    set_ex(1'b1, 5'd11, 32'h99);
    step();
    set_ex(1'b0, 5'd0, 32'd0);
    step();
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    step();
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    set_rd(1'b1, 5'd11, 1'b0, 5'd0);
    #1 chk("r11_lost", bus.rdata1_o, 32'd0);

    // flush alone: commit stage retires, younger entries vanish
    set_ex(1'b1, 5'd6, 32'h77);
    step();
    set_ex(1'b1, 5'd4, 32'h66);
    step();
    bus.flush_i = 1'b1;
    set_ex(1'b1, 5'd12, 32'h88);
    step();
    bus.flush_i = 1'b0;
    set_ex(1'b0, 5'd0, 32'd0);
    set_rd(1'b1, 5'd6, 1'b1, 5'd4);
    #1 chk("r6_committed", bus.rdata1_o, 32'h77);
    chk("r4_dropped", bus.rdata2_o, 32'd0);
    chk("wb_wd_flushed", 32'(bus.wb_wd_o), 32'd0);
    chk("wb_wreg_flushed", 32'(bus.wb_wreg_o), 32'd0);
    chk("wb_wdata_flushed", bus.wb_wdata_o, 32'd0);
    bus.raddr2_i = 5'd12;
    #1 chk("r12_dropped", bus.rdata2_o, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      bus.stall_i = ($urandom_range(0, 9) < 2);
      bus.flush_i = ($urandom_range(0, 14) == 0);
      set_ex(1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
             $urandom());
      set_rd(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 7) != 0),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
